// File: rtl/kdtree_loader_pkg.sv
// Shared types and frame word-count helpers for the k-d tree input loader.
package kdtree_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_NODES   = 2'd1,
    S_LEAVES  = 2'd2,
    S_QUERIES = 2'd3
  } state_t;

  function automatic logic [31:0] node_words(input int num_leaves);
    return 32'(2 * (num_leaves - 1));
  endfunction

  function automatic logic [31:0] leaf_words(input int num_leaves, input int leaf_size,
                                             input int patch_size);
    return 32'(num_leaves * leaf_size * (patch_size + 1));
  endfunction

  function automatic logic [31:0] query_words(input int num_querys, input int patch_size);
    return 32'(num_querys * patch_size);
  endfunction

endpackage

// File: rtl/kdtree_input_loader_patch_assembler.sv
// PATCH_SIZE-deep word shift register; the first word shifted in ends up in the LSBs.
module patch_assembler #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_clr,
  input  logic                             i_shift,
  input  logic [DATA_WIDTH-1:0]            i_word,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] o_words,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] o_words_next,
  output logic                             o_full,
  output logic                             o_last
);
  localparam int PW    = PATCH_SIZE * DATA_WIDTH;
  localparam int CNT_W = $clog2(PATCH_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PATCH_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PATCH_SIZE - 1);

  logic [PW-1:0]    r_words;
  logic [CNT_W-1:0] r_count;
  logic [PW-1:0]    w_shifted;

  assign w_shifted = {i_word, r_words[PW-1:DATA_WIDTH]};

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_words <= '0;
      r_count <= '0;
    end else if (i_shift) begin
      r_words <= w_shifted;
      r_count <= r_count + 1'b1;
    end
  end

  assign o_words      = r_words;
  assign o_words_next = w_shifted;
  assign o_full       = (r_count == CNT_FULL);
  assign o_last       = (r_count == CNT_LAST);

endmodule

// File: rtl/kdtree_input_loader.sv
// Streams one k-d tree frame (nodes, leaf patches, query patches) from a FWFT FIFO into write ports.
// Optional dim range check with sticky err: define LOADER_RANGE_CHECK_EN.
module kdtree_input_loader
  import kdtree_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int LEAF_SIZE  = 8,
  parameter int NUM_LEAVES = 64,
  parameter int NUM_QUERYS = 494,
  parameter int IDX_WIDTH  = 9
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      load_kdtree,
  input  logic [DATA_WIDTH-1:0]                     fifo_rdata,
  input  logic                                      fifo_rempty_n,
  output logic                                      fifo_deq,
  output logic                                      node_wen,
  output logic [$clog2(NUM_LEAVES-1)-1:0]           node_waddr,
  output logic [$clog2(PATCH_SIZE)-1:0]             node_dim,
  output logic [DATA_WIDTH-1:0]                     node_median,
  output logic                                      leaf_wen,
  output logic [$clog2(NUM_LEAVES)-1:0]             leaf_waddr,
  output logic [$clog2(LEAF_SIZE)-1:0]              leaf_slot,
  output logic [PATCH_SIZE*DATA_WIDTH+IDX_WIDTH-1:0] leaf_wdata,
  output logic                                      query_wen,
  output logic [$clog2(NUM_QUERYS)-1:0]             query_waddr,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0]          query_wdata,
  output logic                                      busy,
  output logic                                      kdtree_done,
  output logic                                      query_done,
  output logic                                      err
);
  localparam int NUM_NODES = NUM_LEAVES - 1;
  localparam int NADDR_W   = $clog2(NUM_NODES);
  localparam int DIM_W     = $clog2(PATCH_SIZE);
  localparam int LADDR_W   = $clog2(NUM_LEAVES);
  localparam int SLOT_W    = $clog2(LEAF_SIZE);
  localparam int QADDR_W   = $clog2(NUM_QUERYS);
  localparam int PW        = PATCH_SIZE * DATA_WIDTH;
  localparam int LEAF_W    = PW + IDX_WIDTH;

  localparam logic [31:0] NODE_LAST  = node_words(NUM_LEAVES) - 32'd1;
  localparam logic [31:0] LEAF_LAST  = leaf_words(NUM_LEAVES, LEAF_SIZE, PATCH_SIZE) - 32'd1;
  localparam logic [31:0] QUERY_LAST = query_words(NUM_QUERYS, PATCH_SIZE) - 32'd1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LEAF_SIZE - 1);

  state_t r_state, w_next_state;
  logic   w_deq, w_phase_end;
  logic [31:0] r_word_cnt;

  logic               r_have_dim;
  logic [DIM_W-1:0]   r_dim;
  logic [NADDR_W-1:0] r_node_cnt;
  logic [LADDR_W-1:0] r_leaf_cnt;
  logic [SLOT_W-1:0]  r_slot;
  logic [QADDR_W-1:0] r_query_cnt;

  logic               r_node_wen, r_leaf_wen, r_query_wen, r_kd_done, r_q_done;
  logic [NADDR_W-1:0] r_node_waddr;
  logic [DIM_W-1:0]   r_node_dim;
  logic [DATA_WIDTH-1:0] r_node_median;
  logic [LADDR_W-1:0] r_leaf_waddr;
  logic [SLOT_W-1:0]  r_leaf_slot;
  logic [LEAF_W-1:0]  r_leaf_wdata;
  logic [QADDR_W-1:0] r_query_waddr;
  logic [PW-1:0]      r_query_wdata;

  logic          w_asm_shift, w_asm_clr, w_asm_full, w_asm_last;
  logic [PW-1:0] w_asm_words, w_asm_next;

  // Nothing is consumed while idle or during the reset cycle itself.
  assign w_deq = !rst && (r_state != S_IDLE) && fifo_rempty_n;

  always_comb begin
    w_phase_end = 1'b0;
    case (r_state)
      S_NODES:   w_phase_end = (r_word_cnt == NODE_LAST);
      S_LEAVES:  w_phase_end = (r_word_cnt == LEAF_LAST);
      S_QUERIES: w_phase_end = (r_word_cnt == QUERY_LAST);
      default:   w_phase_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (load_kdtree)           w_next_state = S_NODES;
      S_NODES:   if (w_deq && w_phase_end)  w_next_state = S_LEAVES;
      S_LEAVES:  if (w_deq && w_phase_end)  w_next_state = S_QUERIES;
      S_QUERIES: if (w_deq && w_phase_end)  w_next_state = S_IDLE;
      default:                              w_next_state = S_IDLE;
    endcase
  end

  assign w_asm_shift = w_deq && (((r_state == S_LEAVES) && !w_asm_full) ||
                                 ((r_state == S_QUERIES) && !w_asm_last));
  assign w_asm_clr   = w_deq && (((r_state == S_LEAVES) && w_asm_full) ||
                                 ((r_state == S_QUERIES) && w_asm_last));

  patch_assembler #(
    .DATA_WIDTH (DATA_WIDTH),
    .PATCH_SIZE (PATCH_SIZE)
  ) u_patch_assembler (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_asm_clr),
    .i_shift      (w_asm_shift),
    .i_word       (fifo_rdata),
    .o_words      (w_asm_words),
    .o_words_next (w_asm_next),
    .o_full       (w_asm_full),
    .o_last       (w_asm_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_cnt    <= '0;
      r_have_dim    <= 1'b0;
      r_dim         <= '0;
      r_node_cnt    <= '0;
      r_leaf_cnt    <= '0;
      r_slot        <= '0;
      r_query_cnt   <= '0;
      r_node_wen    <= 1'b0;
      r_leaf_wen    <= 1'b0;
      r_query_wen   <= 1'b0;
      r_kd_done     <= 1'b0;
      r_q_done      <= 1'b0;
      r_node_waddr  <= '0;
      r_node_dim    <= '0;
      r_node_median <= '0;
      r_leaf_waddr  <= '0;
      r_leaf_slot   <= '0;
      r_leaf_wdata  <= '0;
      r_query_waddr <= '0;
      r_query_wdata <= '0;
    end else begin
      r_node_wen  <= 1'b0;
      r_leaf_wen  <= 1'b0;
      r_query_wen <= 1'b0;
      r_kd_done   <= 1'b0;
      r_q_done    <= 1'b0;
      if (r_state == S_IDLE) begin
        r_word_cnt  <= '0;
        r_have_dim  <= 1'b0;
        r_node_cnt  <= '0;
        r_leaf_cnt  <= '0;
        r_slot      <= '0;
        r_query_cnt <= '0;
      end else if (w_deq) begin
        r_word_cnt <= w_phase_end ? '0 : r_word_cnt + 32'd1;
        case (r_state)
          S_NODES: begin
            if (!r_have_dim) begin
              r_have_dim <= 1'b1;
              r_dim      <= fifo_rdata[DIM_W-1:0];
            end else begin
              r_have_dim    <= 1'b0;
              r_node_wen    <= 1'b1;
              r_node_waddr  <= r_node_cnt;
              r_node_dim    <= r_dim;
              r_node_median <= fifo_rdata;
              r_node_cnt    <= r_node_cnt + 1'b1;
            end
          end
          S_LEAVES: begin
            // With the patch full, the current word is the original-image index.
            if (w_asm_full) begin
              r_leaf_wen   <= 1'b1;
              r_leaf_waddr <= r_leaf_cnt;
              r_leaf_slot  <= r_slot;
              r_leaf_wdata <= {fifo_rdata[IDX_WIDTH-1:0], w_asm_words};
              r_kd_done    <= w_phase_end;
              if (r_slot == LAST_SLOT) begin
                r_slot     <= '0;
                r_leaf_cnt <= r_leaf_cnt + 1'b1;
              end else begin
                r_slot <= r_slot + 1'b1;
              end
            end
          end
          S_QUERIES: begin
            if (w_asm_last) begin
              r_query_wen   <= 1'b1;
              r_query_waddr <= r_query_cnt;
              r_query_wdata <= w_asm_next;
              r_query_cnt   <= r_query_cnt + 1'b1;
              r_q_done      <= w_phase_end;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LOADER_RANGE_CHECK_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else if (w_deq && (r_state == S_NODES) && !r_have_dim &&
             (fifo_rdata >= DATA_WIDTH'(PATCH_SIZE)))
      r_err <= 1'b1;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign fifo_deq    = w_deq;
  assign busy        = (r_state != S_IDLE);
  assign node_wen    = r_node_wen;
  assign node_waddr  = r_node_waddr;
  assign node_dim    = r_node_dim;
  assign node_median = r_node_median;
  assign leaf_wen    = r_leaf_wen;
  assign leaf_waddr  = r_leaf_waddr;
  assign leaf_slot   = r_leaf_slot;
  assign leaf_wdata  = r_leaf_wdata;
  assign query_wen   = r_query_wen;
  assign query_waddr = r_query_waddr;
  assign query_wdata = r_query_wdata;
  assign kdtree_done = r_kd_done;
  assign query_done  = r_q_done;

endmodule

// File: tb/tb_kdtree_input_loader.sv
// Randomized frame bench for kdtree_input_loader; expected writes derived from word positions in the frame.
module tb_kdtree_input_loader;
  localparam int NW    = 126;
  localparam int LW    = 3072;
  localparam int QW    = 2470;
  localparam int TOTAL = NW + LW + QW;
  localparam int BUDGET = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_kdtree = 1'b0;
  logic [10:0] fifo_rdata = '0;
  logic        fifo_rempty_n = 1'b0;
  logic        fifo_deq, node_wen, leaf_wen, query_wen, busy, kdtree_done, query_done, err;
  logic [5:0]  node_waddr, leaf_waddr;
  logic [2:0]  node_dim, leaf_slot;
  logic [10:0] node_median;
  logic [63:0] leaf_wdata;
  logic [8:0]  query_waddr;
  logic [54:0] query_wdata;

  kdtree_input_loader dut (
    .clk(clk), .rst(rst), .load_kdtree(load_kdtree), .fifo_rdata(fifo_rdata),
    .fifo_rempty_n(fifo_rempty_n), .fifo_deq(fifo_deq), .node_wen(node_wen),
    .node_waddr(node_waddr), .node_dim(node_dim), .node_median(node_median),
    .leaf_wen(leaf_wen), .leaf_waddr(leaf_waddr), .leaf_slot(leaf_slot),
    .leaf_wdata(leaf_wdata), .query_wen(query_wen), .query_waddr(query_waddr),
    .query_wdata(query_wdata), .busy(busy), .kdtree_done(kdtree_done),
    .query_done(query_done), .err(err)
  );

  always #5 clk = ~clk;

  logic [10:0] frame [TOTAL];
  int  checks = 0, errors = 0;
  int  cons = 0;
  bit  mbusy = 0, merr = 0, fifo_on = 0;
  int  n_node, n_leaf, n_query, n_kd, n_qd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gen_frame(input bit bad_dim);
    for (int i = 0; i < TOTAL; i++) frame[i] = 11'($urandom_range(0, 2047));
    for (int i = 0; i < NW; i += 2) frame[i] = 11'($urandom_range(0, 4));
    frame[0] = 11'd3;
    frame[1] = 11'd700;
    for (int i = 0; i < 5; i++) frame[NW+i] = 11'(i + 1);
    frame[NW+5] = 11'd300;
    if (bad_dim) frame[10] = 11'd6;
  endtask

  task automatic step(input bit allow, input bit ld);
    int c, k, off;
    bit ed, en, el, eq, ekd, eqd;
    logic [63:0] e_naddr, e_dim, e_med, e_laddr, e_slot, e_ldata, e_qaddr, e_qdata;
    @(negedge clk);
    rst = 1'b0;
    load_kdtree = ld;
    if (fifo_on && cons < TOTAL && allow) begin
      fifo_rempty_n = 1'b1;
      fifo_rdata = frame[cons];
    end else begin
      fifo_rempty_n = 1'b0;
      fifo_rdata = 11'($urandom_range(0, 2047));
    end
    #1;
    ed = fifo_rempty_n && mbusy;
    chk("fifo_deq", 64'(fifo_deq), 64'(ed));
    @(posedge clk);
    #1;
    en = 0; el = 0; eq = 0; ekd = 0; eqd = 0;
    e_naddr = 0; e_dim = 0; e_med = 0; e_laddr = 0; e_slot = 0; e_ldata = 0; e_qaddr = 0; e_qdata = 0;
    if (ld && !mbusy) mbusy = 1;
    else if (ed) begin
      c = cons;
      cons++;
      if (c < NW) begin
        if (c % 2 == 0) begin
`ifdef LOADER_RANGE_CHECK_EN
          if (frame[c] >= 11'd5) merr = 1;
`endif
        end else begin
          en = 1;
          k = c / 2;
          e_naddr = 64'(k);
          e_dim = 64'(frame[c-1] & 11'h7);
          e_med = 64'(frame[c]);
        end
      end else if (c < NW + LW) begin
        off = c - NW;
        if (off % 6 == 5) begin
          k = off / 6;
          el = 1;
          ekd = (k == 511);
          e_laddr = 64'(k / 8);
          e_slot = 64'(k % 8);
          e_ldata = 64'(frame[c] & 11'h1ff);
          for (int j = 1; j <= 5; j++) e_ldata = (e_ldata << 11) | 64'(frame[c-j]);
        end
      end else begin
        off = c - NW - LW;
        if (off % 5 == 4) begin
          k = off / 5;
          eq = 1;
          eqd = (k == 493);
          e_qaddr = 64'(k);
          for (int j = 0; j < 5; j++) e_qdata = (e_qdata << 11) | 64'(frame[c-j]);
        end
      end
      if (cons == TOTAL) mbusy = 0;
    end
    chk("node_wen", 64'(node_wen), 64'(en));
    if (en) begin
      chk("node_waddr", 64'(node_waddr), e_naddr);
      chk("node_dim", 64'(node_dim), e_dim);
      chk("node_median", 64'(node_median), e_med);
    end
    chk("leaf_wen", 64'(leaf_wen), 64'(el));
    chk("kdtree_done", 64'(kdtree_done), 64'(ekd));
    if (el) begin
      chk("leaf_waddr", 64'(leaf_waddr), e_laddr);
      chk("leaf_slot", 64'(leaf_slot), e_slot);
      chk("leaf_wdata", leaf_wdata, e_ldata);
    end
    chk("query_wen", 64'(query_wen), 64'(eq));
    chk("query_done", 64'(query_done), 64'(eqd));
    if (eq) begin
      chk("query_waddr", 64'(query_waddr), e_qaddr);
      chk("query_wdata", 64'(query_wdata), e_qdata);
    end
    chk("busy", 64'(busy), 64'(mbusy));
    chk("err", 64'(err), 64'(merr));
    n_node += int'(node_wen);
    n_leaf += int'(leaf_wen);
    n_query += int'(query_wen);
    n_kd += int'(kdtree_done);
    n_qd += int'(query_done);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1;
      load_kdtree = 1'b0;
      fifo_rempty_n = 1'b1;
      fifo_rdata = 11'($urandom_range(0, 2047));
      #1;
      chk("rst_fifo_deq", 64'(fifo_deq), 64'd0);
      @(posedge clk);
      #1;
      chk("rst_node_wen", 64'(node_wen), 64'd0);
      chk("rst_node_waddr", 64'(node_waddr), 64'd0);
      chk("rst_node_dim", 64'(node_dim), 64'd0);
      chk("rst_node_median", 64'(node_median), 64'd0);
      chk("rst_leaf_wen", 64'(leaf_wen), 64'd0);
      chk("rst_leaf_waddr", 64'(leaf_waddr), 64'd0);
      chk("rst_leaf_slot", 64'(leaf_slot), 64'd0);
      chk("rst_leaf_wdata", leaf_wdata, 64'd0);
      chk("rst_query_wen", 64'(query_wen), 64'd0);
      chk("rst_query_waddr", 64'(query_waddr), 64'd0);
      chk("rst_query_wdata", 64'(query_wdata), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_kdtree_done", 64'(kdtree_done), 64'd0);
      chk("rst_query_done", 64'(query_done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
    end
    mbusy = 0;
    merr = 0;
    cons = 0;
    fifo_on = 0;
  endtask

  task automatic run_frame(input bit gaps, input int stop_at, input bit bad_dim);
    int cyc;
    bit gap_done, ld_done, allow;
    gen_frame(bad_dim);
    cons = 0;
    fifo_on = 1;
    n_node = 0; n_leaf = 0; n_query = 0; n_kd = 0; n_qd = 0;
    step(1'b1, 1'b1);
    cyc = 0;
    gap_done = 0;
    ld_done = 0;
    while (mbusy && cons < stop_at && cyc < BUDGET) begin
      if (!gap_done && cons == NW + LW + 100) begin
        gap_done = 1;
        for (int g = 0; g < 10; g++) step(1'b0, 1'b0);
        cyc += 10;
      end
      allow = gaps ? ($urandom_range(0, 9) != 0) : 1'b1;
      if (!ld_done && cons == 500) begin
        ld_done = 1;
        step(allow, 1'b1);
      end else begin
        step(allow, 1'b0);
      end
      cyc++;
    end
    chk("frame_timeout", 64'(cyc < BUDGET), 64'd1);
  endtask

  initial begin
    do_reset(3);

    run_frame(1'b0, TOTAL, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("f1_node_count", 64'(n_node), 64'd63);
    chk("f1_leaf_count", 64'(n_leaf), 64'd512);
    chk("f1_query_count", 64'(n_query), 64'd494);
    chk("f1_kd_done_count", 64'(n_kd), 64'd1);
    chk("f1_q_done_count", 64'(n_qd), 64'd1);
    chk("f1_idle", 64'(busy), 64'd0);

    run_frame(1'b1, NW + 1000, 1'b0);
    chk("f2_busy_before_rst", 64'(busy), 64'd1);
    do_reset(2);

    run_frame(1'b1, TOTAL, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("f3_node_count", 64'(n_node), 64'd63);
    chk("f3_leaf_count", 64'(n_leaf), 64'd512);
    chk("f3_query_count", 64'(n_query), 64'd494);
    chk("f3_kd_done_count", 64'(n_kd), 64'd1);
    chk("f3_q_done_count", 64'(n_qd), 64'd1);
    chk("f3_idle", 64'(busy), 64'd0);

    run_frame(1'b1, NW + 20, 1'b1);
`ifdef LOADER_RANGE_CHECK_EN
    chk("bad_dim_err", 64'(err), 64'd1);
`else
    chk("bad_dim_err", 64'(err), 64'd0);
`endif
    do_reset(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
